des_key_schedule: RTL



---
 rtl/des_key_schedule.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/des_key_schedule.sv
// -----------------------------------------------------------------------------
// des_key_schedule
// Builds the sixteen 48-bit DES round keys from one 64-bit key, one round per
// clock. The keys are presented together on a 768-bit bus for a datapath that
// runs four rounds per cycle. Encrypt order puts K1 in slot 0. Decrypt order
// puts K16 in slot 0. The finished bus is held until the next accepted start.
//
// Ports
//   clk         system clock, all state on the rising edge
//   rst         synchronous active-high reset; overrides start and aborts a run
//   start       request a new schedule (ignored while busy)
//   decrypt     sampled with start; 1 = reverse slot order
//   key         64-bit DES key, DES bit 1 = key[63]; parity bits are ignored
//   busy        high while rounds are being generated
//   keys_valid  high while round_keys holds a complete schedule
//   round_keys  slot s = round_keys[767-48s -: 48], round-key bit 1 = slot MSB
// -----------------------------------------------------------------------------
module des_key_schedule (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         decrypt,
  input  logic [63:0]  key,
  output logic         busy,
  output logic         keys_valid,
  output logic [767:0] round_keys
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Permuted choice 1: entry i gives the DES key bit (1-based) for CD bit i+1.
  localparam logic [7:0] PC1_TAB [56] = '{
    8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,
    8'd1,  8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18,
    8'd10, 8'd2,  8'd59, 8'd51, 8'd43, 8'd35, 8'd27,
    8'd19, 8'd11, 8'd3,  8'd60, 8'd52, 8'd44, 8'd36,
    8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15,
    8'd7,  8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22,
    8'd14, 8'd6,  8'd61, 8'd53, 8'd45, 8'd37, 8'd29,
    8'd21, 8'd13, 8'd5,  8'd28, 8'd20, 8'd12, 8'd4
  };

  // Permuted choice 2: entry i gives the CD bit (1-based) for round-key bit i+1.
  localparam logic [7:0] PC2_TAB [48] = '{
    8'd14, 8'd17, 8'd11, 8'd24, 8'd1,  8'd5,
    8'd3,  8'd28, 8'd15, 8'd6,  8'd21, 8'd10,
    8'd23, 8'd19, 8'd12, 8'd4,  8'd26, 8'd8,
    8'd16, 8'd7,  8'd27, 8'd20, 8'd13, 8'd2,
    8'd41, 8'd52, 8'd31, 8'd37, 8'd47, 8'd55,
    8'd30, 8'd40, 8'd51, 8'd45, 8'd33, 8'd48,
    8'd44, 8'd49, 8'd39, 8'd56, 8'd34, 8'd53,
    8'd46, 8'd42, 8'd50, 8'd36, 8'd29, 8'd32
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] o;
    o = 56'd0;
    for (int i = 0; i < 56; i++) begin
      o[32'sd55 - i] = k[32'sd64 - int'(PC1_TAB[i])];
    end
    return o;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] o;
    o = 48'd0;
    for (int i = 0; i < 48; i++) begin
      o[32'sd47 - i] = cd[32'sd56 - int'(PC2_TAB[i])];
    end
    return o;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] v, input logic by_two);
    return by_two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
  endfunction

  state_e      state_q;
  logic [4:0]  rnd_q;          // 1..16 during generation, needs five bits
  logic [27:0] c_q, d_q;
  logic [27:0] c_d, d_d;
  logic        dec_q;
  logic        busy_q, valid_q;
  logic [47:0] slots_q [16];
  logic        one_shift_s;
  logic [47:0] rk_s;
  logic [3:0]  slot_s;
  logic [55:0] pc1_s;
  logic        unused_parity_s;

  // DES parity bits never enter the schedule.
  assign unused_parity_s = ^{key[56], key[48], key[40], key[32],
                             key[24], key[16], key[8],  key[0]};

  assign pc1_s = pc1(key);

  // Rotated C/D for the current round, its round key and destination slot.
  always_comb begin
    one_shift_s = (rnd_q == 5'd1) || (rnd_q == 5'd2) ||
                  (rnd_q == 5'd9) || (rnd_q == 5'd16);
    c_d  = rotl28(c_q, !one_shift_s);
    d_d  = rotl28(d_q, !one_shift_s);
    rk_s = pc2({c_d, d_d});
    if (dec_q) begin
      slot_s = 4'(5'd16 - rnd_q);
    end else begin
      slot_s = 4'(rnd_q - 5'd1);
    end
  end

  // Control FSM plus all schedule state; every output comes from these flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rnd_q   <= 5'd0;
      c_q     <= 28'd0;
      d_q     <= 28'd0;
      dec_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      for (int s = 0; s < 16; s++) begin
        slots_q[s] <= 48'd0;
      end
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            c_q     <= pc1_s[55:28];
            d_q     <= pc1_s[27:0];
            rnd_q   <= 5'd1;
            dec_q   <= decrypt;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
            state_q <= ST_GEN;
            for (int s = 0; s < 16; s++) begin
              slots_q[s] <= 48'd0;
            end
          end else begin
            state_q <= state_q;
          end
        end
        ST_GEN: begin
          c_q             <= c_d;
          d_q             <= d_d;
          slots_q[slot_s] <= rk_s;
          rnd_q           <= rnd_q + 5'd1;
          if (rnd_q == 5'd16) begin
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_GEN;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign keys_valid = valid_q;

  // Pack the slot registers onto the bus, slot 0 in the top 48 bits.
  always_comb begin
    round_keys = 768'd0;
    for (int s = 0; s < 16; s++) begin
      round_keys[767 - 48*s -: 48] = slots_q[s];
    end
  end

endmodule
